// File: rtl/sc_ifetch.sv
// rtl/sc_ifetch.sv - instruction-fetch and PC stage with fetch-timeout watchdog
//
// Holds the PC and fetches one instruction per commit over a req/rdy handshake.
// The held word is presented to decode until the CPU commits it. The commit
// then selects the next PC via pcsource: 00 pc+4, 01 branch, 10 jr, 11 jump.
// The FETCH state has a watchdog. If imem_rdy does not arrive within MAX_WAIT
// cycles, the stage enters a terminal ERR state and raises fetch_err.
//
// Optional feature: IF_ALIGN_CHECK_EN. When this macro is defined, a jr commit
// whose rs_val is not word-aligned faults into ERR and leaves pc unchanged.
// When it is undefined, the low two bits of a jr target are cleared.
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   pcsource    in   next-PC select from the control unit
//   rs_val      in   jr target register value
//   commit      in   held instruction has executed; advance the PC
//   imem_req    out  fetch request (high only in FETCH)
//   imem_addr   out  fetch address, always equal to pc
//   imem_rdy    in   instruction memory data valid
//   imem_rdata  in   instruction word
//   inst        out  held instruction
//   inst_valid  out  inst is valid and awaiting commit
//   pc          out  current PC
//   pc4         out  pc + 4 (also the jal link value)
//   fetch_err   out  sticky fault flag
module sc_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] rs_val,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Counter value of the last FETCH cycle that is allowed before the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] pc4_w;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            wait_cnt_q   <= 8'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Next-PC selection. All additions wrap modulo 2^32.
    always_comb begin
        pc4_w  = pc_q + 32'd4;
        br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        case (pcsource)
            2'b00:   next_pc = pc4_w;
            2'b01:   next_pc = pc4_w + br_off;
            2'b10:   next_pc = rs_val & 32'hFFFF_FFFC;
            default: next_pc = {pc4_w[31:28], inst_q[25:0], 2'b00};
        endcase
`ifdef IF_ALIGN_CHECK_EN
        jr_misaligned = (pcsource == 2'b10) && (rs_val[1:0] != 2'b00);
`else
        jr_misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        fetch_err_d  = fetch_err_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // A response in the timeout cycle still completes the fetch.
                if (imem_rdy) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    wait_cnt_d   = 8'h0;
                    state_d      = S_HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (commit) begin
                    inst_valid_d = 1'b0;
                    if (jr_misaligned) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                inst_valid_d = 1'b0;
                fetch_err_d  = 1'b1;
            end
        endcase
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc4        = pc4_w;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_sc_ifetch.sv
// tb/tb_sc_ifetch.sv - self-checking testbench for sc_ifetch
module tb_sc_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 16;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] rs_val = 32'h0;
    logic        commit = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    sc_ifetch #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .rs_val(rs_val),
        .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .inst(inst),
        .inst_valid(inst_valid), .pc(pc), .pc4(pc4), .fetch_err(fetch_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        commit = 1'b0;
        imem_rdy = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    // Wait for a request, answer it after 'delay' idle FETCH cycles, and return
    // with the stage in HOLD.
    task automatic fetch(input logic [31:0] word, input int delay, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !imem_req; i++) step();
        if (!imem_req) return;
        imem_rdy = 1'b0;
        repeat (delay) step();
        imem_rdy = 1'b1;
        imem_rdata = word;
        step();
        imem_rdy = 1'b0;
        imem_rdata = $urandom;
        ok = 1'b1;
    endtask

    task automatic commit_pulse(input logic [1:0] sel, input logic [31:0] rs);
        pcsource = sel;
        rs_val = rs;
        commit = 1'b1;
        step();
        commit = 1'b0;
        pcsource = 2'($urandom);
        rs_val = $urandom;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
        checks++; if (pc4 !== RESET_PC + 32'd4) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", pc4, RESET_PC + 32'd4); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if ({imem_req, inst_valid, fetch_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {imem_req, inst_valid, fetch_err}); end
        step();
        resetn = 1'b1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin failures++; $display("FAIL first_req got=%b addr=%h exp=1 %h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        fetch(32'h2001_0005, 0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_fetch_timeout got=0 exp=1"); end
        checks++; if (inst !== 32'h2001_0005 || inst_valid !== 1'b1) begin failures++; $display("FAIL basic_inst got=%h/%b exp=20010005/1", inst, inst_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL basic_hold_req got=%b exp=0", imem_req); end
        commit_pulse(2'b00, 32'h0);
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL basic_pc got=%h exp=4", pc); end
        checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin failures++; $display("FAIL basic_rereq got=%b/%b exp=1/0", imem_req, inst_valid); end
    endtask

    task automatic test_branch();
        bit ok;
        do_reset();
        fetch($urandom, 0, ok); commit_pulse(2'b00, 0);
        fetch($urandom, 1, ok); commit_pulse(2'b00, 0);
        checks++; if (pc !== 32'h8) begin failures++; $display("FAIL branch_setup got=%h exp=8", pc); end
        fetch(32'h1000_FFFE, 2, ok); commit_pulse(2'b01, 0);
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL branch_back got=%h exp=4", pc); end
        fetch($urandom, 0, ok); commit_pulse(2'b00, 0);
        fetch(32'h1000_0003, 0, ok); commit_pulse(2'b01, 0);
        checks++; if (pc !== 32'h18) begin failures++; $display("FAIL branch_fwd got=%h exp=18", pc); end
    endtask

    task automatic test_jump();
        bit ok;
        do_reset();
        fetch($urandom, 0, ok); commit_pulse(2'b10, 32'h1000_0000);
        checks++; if (pc !== 32'h1000_0000) begin failures++; $display("FAIL jr_setup got=%h exp=10000000", pc); end
        fetch(32'h0800_0040, 0, ok); commit_pulse(2'b11, $urandom);
        checks++; if (pc !== 32'h1000_0100) begin failures++; $display("FAIL jump got=%h exp=10000100", pc); end
        fetch($urandom, 0, ok); commit_pulse(2'b10, 32'h0000_0200);
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL jr got=%h exp=200", pc); end
        fetch($urandom, 0, ok); commit_pulse(2'b10, 32'hFFFF_FFFC);
        checks++; if (pc4 !== 32'h0) begin failures++; $display("FAIL pc4_wrap got=%h exp=0", pc4); end
        fetch($urandom, 0, ok); commit_pulse(2'b00, 0);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", pc); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        step();
        imem_rdy = 1'b0;
        repeat (MAX_WAIT - 1) step();
        checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b/%b exp=1/0", imem_req, fetch_err); end
        step();
        checks++; if ({fetch_err, imem_req, inst_valid} !== 3'b100) begin failures++; $display("FAIL timeout_err got=%b exp=100", {fetch_err, imem_req, inst_valid}); end
        imem_rdy = 1'b1; commit = 1'b1;
        repeat (3) step();
        imem_rdy = 1'b0; commit = 1'b0;
        checks++; if ({fetch_err, imem_req, inst_valid} !== 3'b100 || pc !== RESET_PC) begin failures++; $display("FAIL err_sticky got=%b pc=%h exp=100 %h", {fetch_err, imem_req, inst_valid}, pc, RESET_PC); end
        do_reset();
        fetch(32'hCAFE_0001, MAX_WAIT - 1, ok);
        checks++; if (inst_valid !== 1'b1 || fetch_err !== 1'b0 || inst !== 32'hCAFE_0001) begin failures++; $display("FAIL rdy_last got=%b/%b/%h exp=1/0/cafe0001", inst_valid, fetch_err, inst); end
    endtask

    task automatic test_commit_ignored_and_reset();
        bit ok;
        do_reset();
        step();
        imem_rdy = 1'b0; pcsource = 2'b11; commit = 1'b1;
        repeat (3) step();
        commit = 1'b0;
        checks++; if (pc !== RESET_PC || imem_req !== 1'b1) begin failures++; $display("FAIL commit_in_fetch got=%h/%b exp=%h/1", pc, imem_req, RESET_PC); end
        fetch($urandom, 0, ok); commit_pulse(2'b00, 0);
        fetch(32'h1234_5678, 0, ok);
        checks++; if (pc !== 32'h4 || inst_valid !== 1'b1) begin failures++; $display("FAIL hold_setup got=%h/%b exp=4/1", pc, inst_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (pc !== RESET_PC || {imem_req, inst_valid} !== 2'b00 || inst !== 32'h0) begin failures++; $display("FAIL async_reset got=%h/%b/%h exp=%h/00/0", pc, {imem_req, inst_valid}, inst, RESET_PC); end
        @(posedge clock); #1 resetn = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL restart_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_misaligned_jr();
        bit ok;
        do_reset();
        fetch($urandom, 0, ok);
        commit_pulse(2'b10, 32'h0000_0203);
`ifdef IF_ALIGN_CHECK_EN
        checks++; if (fetch_err !== 1'b1 || pc !== RESET_PC || imem_req !== 1'b0) begin failures++; $display("FAIL jr_misaligned got=%b/%h/%b exp=1/%h/0", fetch_err, pc, imem_req, RESET_PC); end
`else
        checks++; if (fetch_err !== 1'b0 || pc !== 32'h200 || imem_req !== 1'b1) begin failures++; $display("FAIL jr_misaligned got=%b/%h/%b exp=0/200/1", fetch_err, pc, imem_req); end
`endif
    endtask

    // Random commits checked against an architectural PC model.
    task automatic test_random();
        bit ok;
        logic [31:0] exp_pc, word, rs, seq;
        logic [1:0]  sel;
        int          off;
        do_reset();
        exp_pc = RESET_PC;
        for (int n = 0; n < 40; n++) begin
            word = $urandom;
            fetch(word, $urandom_range(0, MAX_WAIT - 1), ok);
            checks++; if (!ok || inst !== word || inst_valid !== 1'b1) begin failures++; $display("FAIL rand_inst[%0d] got=%h/%b exp=%h/1", n, inst, inst_valid, word); end
            sel = 2'($urandom);
            rs = $urandom;
`ifdef IF_ALIGN_CHECK_EN
            rs[1:0] = 2'b00;
`endif
            seq = exp_pc + 32'd4;
            off = int'($signed(word[15:0]));
            case (sel)
                2'b00: exp_pc = seq;
                2'b01: exp_pc = seq + 32'(off * 4);
                2'b10: exp_pc = rs - (rs % 4);
                2'b11: exp_pc = (seq & 32'hF000_0000) + (32'(word[25:0]) * 4);
            endcase
            commit_pulse(sel, rs);
            checks++; if (pc !== exp_pc || imem_addr !== exp_pc || pc4 !== exp_pc + 32'd4 || fetch_err !== 1'b0) begin failures++; $display("FAIL rand_pc[%0d] sel=%0d got=%h/%h/%b exp=%h", n, sel, pc, pc4, fetch_err, exp_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_jump();
        test_timeout();
        test_commit_ignored_and_reset();
        test_misaligned_jr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_ifetch.md
Name: sc_ifetch

Overview:
- Instruction-fetch and PC stage of the single-cycle CPU. Sits directly upstream of the control unit and consumes its pcsource decision.
- Holds the PC and fetches from instruction memory over a req/rdy handshake. Presents the held instruction to decode.
- On commit, computes the next PC from pcsource: sequential, branch, jr, or j/jal.
- Includes a fetch-timeout watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, maximum cycles spent in FETCH without imem_rdy before fault. Legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pcsource  in  2  next-PC select from the control unit: 00 pc+4, 01 branch, 10 jr, 11 jump.
- rs_val  in  32  register rs value, used as the jr target.
- commit  in  1  the CPU has finished executing the held instruction; advance the PC.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equal to pc.
- imem_rdy  in  1  instruction memory data valid this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  held instruction for decode.
- inst_valid  out  1  inst is valid and awaiting commit.
- pc  out  32  current PC.
- pc4  out  32  pc + 4; also the jal link value.
- fetch_err  out  1  sticky fault flag.

Behaviour:
- Reset (resetn low, asynchronous) sets:
  - pc = RESET_PC, inst = 0, inst_valid = 0, fetch_err = 0.
  - wait counter = 0, state = IDLE, imem_req = 0.
- States and transitions:
  - IDLE: imem_req = 0. Moves unconditionally to FETCH on the next clock.
  - FETCH: imem_req = 1, imem_addr = pc.
    - If imem_rdy: inst <= imem_rdata, inst_valid <= 1, counter <= 0, go to HOLD.
    - Else if counter == MAX_WAIT-1: go to ERR, fetch_err <= 1.
    - Else counter increments.
    - imem_rdy in the timeout cycle wins: the fetch completes and no error is raised.
  - HOLD: imem_req = 0, inst stable.
    - On commit: pc <= next_pc, inst_valid <= 0, go to FETCH.
  - ERR: imem_req = 0, inst_valid = 0, fetch_err = 1. Terminal; only reset exits.
- commit outside HOLD is ignored; pc is unchanged.
- imem_rdy outside FETCH is ignored.
- next_pc computation (32-bit, wrap-around modulo 2^32, no overflow detection):
  - 00: pc4.
  - 01: pc4 + ({{14{inst[15]}}, inst[15:0], 2'b00}).
  - 10: rs_val (see Optional Feature for low bits).
  - 11: {pc4[31:28], inst[25:0], 2'b00}.
- pc4 is combinational from pc. pc = 32'hFFFF_FFFC gives pc4 = 0.
- Latency:
  - Minimum 2 cycles from entering FETCH to inst_valid (rdy in the first FETCH cycle → inst_valid high the next cycle).
  - Commit-to-next-request: 1 cycle.
- Reset asserted mid-FETCH or mid-HOLD drops imem_req and inst_valid immediately (asynchronous). Any in-flight imem_rdy is discarded.

Optional Feature:
- Macro name: IF_ALIGN_CHECK_EN.
- Defined: on commit with pcsource = 10 and rs_val[1:0] != 0:
  - pc is not updated.
  - State goes to ERR, fetch_err <= 1.
  - Branch and jump targets are aligned by construction and are not checked.
- Undefined: a jr target loads {rs_val[31:2], 2'b00}; low bits are silently cleared; no fault.

Test Plan:
- Reset release with RESET_PC = 0, imem_rdy held high, imem_rdata = 32'h2001_0005, commit pulse after inst_valid → inst = 32'h2001_0005; pcsource = 00 gives pc = 4 and imem_req reasserted one cycle after commit.
- Branch at pc = 8 with inst[15:0] = 16'hFFFE, pcsource = 01, commit → pc = 8 + 4 - 8 = 32'h4. With inst[15:0] = 16'h0003 → pc = 32'h18.
- Jump at pc = 32'h1000_0000 with inst = 32'h0800_0040, pcsource = 11 → pc = 32'h1000_0100. jr with rs_val = 32'h0000_0200, pcsource = 10 → pc = 32'h200.
- imem_rdy held low for MAX_WAIT = 16 cycles → fetch_err = 1 after the 16th FETCH cycle and imem_req = 0. With rdy arriving exactly on the 16th cycle → inst_valid = 1 and fetch_err = 0.
- Commit pulsed during FETCH, and resetn dropped while in HOLD → pc unchanged by the commit. On reset: inst_valid = 0, pc = RESET_PC immediately (without a clock edge); restarts IDLE → FETCH.
- jr with rs_val = 32'h0000_0203:
  - IF_ALIGN_CHECK_EN defined → fetch_err = 1, pc unchanged.
  - Undefined → pc = 32'h200, no error.
